// File: rtl/alu_control_pipe.sv
// alu_control_pipe: registered, handshaked ALU control decoder.
// Decodes the MIPS OpCode/Function pair into an ALU operation code and holds
// it in an output register with valid/ready flow control. Multiply stalls the
// front end for MUL_CYCLES cycles in total.
// Optional feature macro: ALUCTL_ILLEGAL_TRAP_EN. When it is defined, illegal
// encodings produce an all-ones ALUControl with IllegalOp set. When it is
// undefined, IllegalOp is tied low and illegal encodings leave ALUControl
// unchanged.
module alu_control_pipe #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [5:0]        OpCode,
    input  logic [5:0]        Function,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              IllegalOp,
    output logic              MulBusy
);

    typedef enum logic [1:0] {IDLE, FULL, MUL} state_t;

    // A single-cycle multiply skips the MUL state entirely.
    localparam bit          MUL_DIRECT = (MUL_CYCLES == 1);
    localparam int          MUL_LOAD_I = (MUL_CYCLES >= 2) ? (MUL_CYCLES - 2) : 0;
    localparam logic [3:0]  MUL_LOAD   = MUL_LOAD_I[3:0];
    localparam logic [3:0]  CODE_MUL   = 4'd8;

    state_t     state;
    state_t     next_state;
    logic [3:0] mul_count;
    logic [3:0] dec_code;
    logic       dec_legal;
    logic       dec_mul;
    logic       accept;
    logic       mul_done;

    assign accept   = InValid && InReady;
    assign mul_done = (state == MUL) && (mul_count == 4'd0);
    assign dec_mul  = (OpCode == 6'd0) && (Function == 6'd24);

    // Decode table: R-type by Function, everything else by OpCode.
    always_comb begin
        dec_code  = 4'd0;
        dec_legal = 1'b1;
        if (OpCode == 6'd0) begin
            case (Function)
                6'd32:   dec_code = 4'd0;
                6'd34:   dec_code = 4'd1;
                6'd24:   dec_code = 4'd8;
                6'd36:   dec_code = 4'd2;
                6'd37:   dec_code = 4'd3;
                6'd39:   dec_code = 4'd4;
                6'd38:   dec_code = 4'd5;
                6'd0:    dec_code = 4'd6;
                6'd2:    dec_code = 4'd7;
                6'd42:   dec_code = 4'd9;
                default: dec_legal = 1'b0;
            endcase
        end else begin
            case (OpCode)
                6'd8, 6'd35, 6'd43, 6'd40,
                6'd33, 6'd32, 6'd41: dec_code = 4'd0;
                6'd4:    dec_code = 4'd1;
                6'd9:    dec_code = 4'd10;
                6'd5:    dec_code = 4'd11;
                6'd7:    dec_code = 4'd12;
                6'd6:    dec_code = 4'd13;
                6'd11:   dec_code = 4'd14;
                6'd12:   dec_code = 4'd2;
                6'd13:   dec_code = 4'd3;
                6'd14:   dec_code = 4'd5;
                6'd10:   dec_code = 4'd9;
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic: accepts fill the register, drains without accept empty it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = (dec_mul && !MUL_DIRECT) ? MUL : FULL;
            end
            FULL: begin
                if (accept)        next_state = (dec_mul && !MUL_DIRECT) ? MUL : FULL;
                else if (OutReady) next_state = IDLE;
            end
            MUL: begin
                if (mul_done) next_state = FULL;
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake and status outputs derived from the state.
    always_comb begin
        OutValid = (state == FULL);
        MulBusy  = (state == MUL);
        InReady  = (state == IDLE) || ((state == FULL) && OutReady);
    end

    // Multiply latency counter: loaded on a multiply accept, saturates at zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mul_count <= 4'd0;
        end else if (accept && dec_mul && !MUL_DIRECT) begin
            mul_count <= MUL_LOAD;
        end else if ((state == MUL) && (mul_count != 4'd0)) begin
            mul_count <= mul_count - 4'd1;
        end
    end

    // Result register: loads decoded code on accept or the multiply code at completion.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ALUControl <= '0;
        end else if (mul_done) begin
            ALUControl <= CTRL_W'(CODE_MUL);
        end else if (accept) begin
            if (dec_mul) begin
                if (MUL_DIRECT) ALUControl <= CTRL_W'(CODE_MUL);
            end else if (dec_legal) begin
                ALUControl <= CTRL_W'(dec_code);
            end else begin
`ifdef ALUCTL_ILLEGAL_TRAP_EN
                ALUControl <= '1;
`else
                ALUControl <= ALUControl;
`endif
            end
        end
    end

`ifdef ALUCTL_ILLEGAL_TRAP_EN
    // Illegal flag travels with the result; legal and multiply results clear it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            IllegalOp <= 1'b0;
        end else if (mul_done) begin
            IllegalOp <= 1'b0;
        end else if (accept && !(dec_mul && !MUL_DIRECT)) begin
            IllegalOp <= !dec_legal;
        end
    end
`else
    assign IllegalOp = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// tb_alu_control_pipe: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the decoder pipe.
module tb_alu_control_pipe;

    localparam int CW = 4;
    localparam int MC = 3;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [5:0]    OpCode = 6'd0;
    logic [5:0]    Function = 6'd0;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic [CW-1:0] ALUControl;
    logic          IllegalOp;
    logic          MulBusy;

    logic          c1_reset = 1'b1;
    logic          c1_in_valid = 1'b0;
    logic          c1_in_ready;
    logic [5:0]    c1_op = 6'd0;
    logic [5:0]    c1_fn = 6'd0;
    logic          c1_out_valid;
    logic          c1_out_ready = 1'b1;
    logic [CW-1:0] c1_ctrl;
    logic          c1_illegal;
    logic          c1_mul_busy;

    int vectors = 0;
    int miscompares = 0;

    alu_control_pipe #(.CTRL_W(CW), .MUL_CYCLES(MC)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .OpCode(OpCode), .Function(Function), .OutValid(OutValid),
        .OutReady(OutReady), .ALUControl(ALUControl), .IllegalOp(IllegalOp),
        .MulBusy(MulBusy)
    );

    alu_control_pipe #(.CTRL_W(CW), .MUL_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(c1_reset), .InValid(c1_in_valid), .InReady(c1_in_ready),
        .OpCode(c1_op), .Function(c1_fn), .OutValid(c1_out_valid),
        .OutReady(c1_out_ready), .ALUControl(c1_ctrl), .IllegalOp(c1_illegal),
        .MulBusy(c1_mul_busy)
    );

    always #5 Clk = ~Clk;

    // Reference model: a held result plus a countdown of cycles to a multiply result.
    int            rmap[int];
    int            omap[int];
    bit            m_valid = 0;
    logic [CW-1:0] m_ctrl = '0;
    bit            m_ill = 0;
    int            m_left = 0;

    function automatic bit exp_ready();
        return (m_left == 0) && (!m_valid || OutReady);
    endfunction

    always @(posedge Clk) begin : model_update
        bit legal;
        int code;
        if (Reset) begin
            m_valid = 0; m_ctrl = '0; m_ill = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_valid = 1; m_ctrl = CW'(8); m_ill = 0; end
        end else if (InValid && exp_ready()) begin
            legal = (OpCode == 0) ? rmap.exists(int'(Function)) : omap.exists(int'(OpCode));
            code  = !legal ? -1 : (OpCode == 0) ? rmap[int'(Function)] : omap[int'(OpCode)];
            if (code == 8) begin
                m_left = MC - 1;
                m_valid = (m_left == 0);
                if (m_left == 0) begin m_ctrl = CW'(8); m_ill = 0; end
            end else if (legal) begin
                m_valid = 1; m_ctrl = CW'(code); m_ill = 0;
            end else begin
                m_valid = 1;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
                m_ctrl = '1; m_ill = 1;
`else
                m_ill = 0;
`endif
            end
        end else if (m_valid && OutReady) begin
            m_valid = 0;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input bit iv, input int op, input int fn, input bit ordy);
        InValid = iv; OpCode = 6'(op); Function = 6'(fn); OutReady = ordy;
    endtask

    task automatic go_idle();
        drive(0, 0, 0, 1);
        repeat (MC + 2) step();
    endtask

    task automatic test_reset();
        drive(1, 0, 24, 0);
        Reset = 1;
        repeat (2) begin
            @(negedge Clk);
            vectors++;
            if (OutValid !== 1'b0 || ALUControl !== '0 || IllegalOp !== 1'b0 || MulBusy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_values: got valid=%0b ctrl=%0d ill=%0b busy=%0b want 0/0/0/0",
                         OutValid, ALUControl, IllegalOp, MulBusy);
            end
            step();
        end
        Reset = 0;
        drive(1, 0, 32, 1);
        @(negedge Clk);
        vectors++;
        if (InReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_reset: got %0b want 1", InReady);
        end
        step();
        drive(0, 0, 0, 1);
        @(negedge Clk);
        vectors++;
        if (OutValid !== 1'b1 || ALUControl !== CW'(0) || IllegalOp !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL add_result: got valid=%0b ctrl=%0d ill=%0b want 1/0/0",
                     OutValid, ALUControl, IllegalOp);
        end
        step();
    endtask

    task automatic test_stream();
        int ops[3]  = '{4, 5, 13};
        int want[3] = '{1, 11, 3};
        go_idle();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1, ops[i], 0, 1);
            else       drive(0, 0, 0, 1);
            @(negedge Clk);
            if (i > 0) begin
                vectors++;
                if (OutValid !== 1'b1 || ALUControl !== CW'(want[i-1])) begin
                    miscompares++;
                    $display("[TB] FAIL stream_%0d: got valid=%0b ctrl=%0d want 1/%0d",
                             i, OutValid, ALUControl, want[i-1]);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        go_idle();
        drive(1, 12, 0, 1);
        step();
        drive(1, 10, 0, 1);
        step();
        drive(1, 9, 0, 0);
        repeat (3) begin
            @(negedge Clk);
            vectors++;
            if (OutValid !== 1'b1 || ALUControl !== CW'(9) || InReady !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hold: got valid=%0b ctrl=%0d ready=%0b want 1/9/0",
                         OutValid, ALUControl, InReady);
            end
            step();
        end
        OutReady = 1;
        @(negedge Clk);
        vectors++;
        if (InReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drain_ready: got %0b want 1", InReady);
        end
        step();
        drive(0, 0, 0, 1);
        @(negedge Clk);
        vectors++;
        if (OutValid !== 1'b1 || ALUControl !== CW'(10)) begin
            miscompares++;
            $display("[TB] FAIL after_drain: got valid=%0b ctrl=%0d want 1/10", OutValid, ALUControl);
        end
        step();
    endtask

    task automatic test_mul();
        go_idle();
        drive(1, 0, 24, 1);
        step();
        drive(1, 8, 0, 1);
        for (int k = 1; k <= MC; k++) begin
            @(negedge Clk);
            vectors++;
            if (k < MC) begin
                if (MulBusy !== 1'b1 || InReady !== 1'b0 || OutValid !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL mul_busy_%0d: got busy=%0b ready=%0b valid=%0b want 1/0/0",
                             k, MulBusy, InReady, OutValid);
                end
            end else begin
                if (MulBusy !== 1'b0 || OutValid !== 1'b1 || ALUControl !== CW'(8)) begin
                    miscompares++;
                    $display("[TB] FAIL mul_result: got busy=%0b valid=%0b ctrl=%0d want 0/1/8",
                             MulBusy, OutValid, ALUControl);
                end
            end
            step();
        end
        drive(0, 0, 0, 1);
        @(negedge Clk);
        vectors++;
        if (OutValid !== 1'b1 || ALUControl !== CW'(0)) begin
            miscompares++;
            $display("[TB] FAIL after_mul: got valid=%0b ctrl=%0d want 1/0", OutValid, ALUControl);
        end
        step();
    endtask

    task automatic test_mul_single();
        c1_reset = 1;
        step();
        c1_reset = 0;
        c1_in_valid = 1; c1_op = 6'd0; c1_fn = 6'd24; c1_out_ready = 1;
        @(negedge Clk);
        vectors++;
        if (c1_in_ready !== 1'b1 || c1_mul_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mul1_accept: got ready=%0b busy=%0b want 1/0", c1_in_ready, c1_mul_busy);
        end
        step();
        c1_in_valid = 0;
        @(negedge Clk);
        vectors++;
        if (c1_out_valid !== 1'b1 || c1_ctrl !== CW'(8) || c1_mul_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mul1_result: got valid=%0b ctrl=%0d busy=%0b want 1/8/0",
                     c1_out_valid, c1_ctrl, c1_mul_busy);
        end
        step();
    endtask

    task automatic test_illegal();
        logic [CW-1:0] want_ctrl;
        bit            want_ill;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
        want_ctrl = '1; want_ill = 1;
`else
        want_ctrl = CW'(9); want_ill = 0;
`endif
        go_idle();
        drive(1, 0, 42, 1);
        step();
        drive(1, 63, 0, 1);
        step();
        drive(0, 0, 0, 1);
        @(negedge Clk);
        vectors++;
        if (OutValid !== 1'b1 || ALUControl !== want_ctrl || IllegalOp !== want_ill) begin
            miscompares++;
            $display("[TB] FAIL illegal: got valid=%0b ctrl=%0d ill=%0b want 1/%0d/%0b",
                     OutValid, ALUControl, IllegalOp, want_ctrl, want_ill);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        bit seen8;
        go_idle();
        drive(1, 0, 24, 1);
        step();
        drive(0, 0, 0, 1);
        step();
        Reset = 1;
        step();
        Reset = 0;
        @(negedge Clk);
        vectors++;
        if (OutValid !== 1'b0 || MulBusy !== 1'b0 || InReady !== 1'b1 || ALUControl !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_mul: got valid=%0b busy=%0b ready=%0b ctrl=%0d want 0/0/1/0",
                     OutValid, MulBusy, InReady, ALUControl);
        end
        seen8 = 0;
        repeat (MC + 2) begin
            step();
            @(negedge Clk);
            if (OutValid === 1'b1) seen8 = 1;
        end
        vectors++;
        if (seen8) begin
            miscompares++;
            $display("[TB] FAIL ghost_mul: got a result after reset, want none");
        end
        step();
    endtask

    task automatic test_back_to_back();
        go_idle();
        drive(1, 14, 0, 0);
        step();
        drive(0, 0, 0, 0);
        @(negedge Clk);
        vectors++;
        if (OutValid !== 1'b1 || ALUControl !== CW'(5)) begin
            miscompares++;
            $display("[TB] FAIL xori_held: got valid=%0b ctrl=%0d want 1/5", OutValid, ALUControl);
        end
        step();
        drive(1, 0, 0, 1);
        @(negedge Clk);
        vectors++;
        if (InReady !== 1'b1 || OutValid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drain_accept: got ready=%0b valid=%0b want 1/1", InReady, OutValid);
        end
        step();
        drive(0, 0, 0, 1);
        @(negedge Clk);
        vectors++;
        if (OutValid !== 1'b1 || ALUControl !== CW'(6)) begin
            miscompares++;
            $display("[TB] FAIL sll_no_bubble: got valid=%0b ctrl=%0d want 1/6", OutValid, ALUControl);
        end
        step();
    endtask

    task automatic test_random();
        int rfn[10]  = '{32, 34, 24, 36, 37, 39, 38, 0, 2, 42};
        int rops[17] = '{8, 35, 43, 40, 33, 32, 41, 4, 9, 5, 7, 6, 11, 12, 13, 14, 10};
        int sel;
        for (int n = 0; n < 1500; n++) begin
            Reset = ($urandom_range(0, 79) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 4)
                drive($urandom_range(0, 9) < 7, 0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : rfn[$urandom_range(0, 9)],
                      $urandom_range(0, 9) < 7);
            else if (sel < 9)
                drive($urandom_range(0, 9) < 7, rops[$urandom_range(0, 16)], $urandom_range(0, 63),
                      $urandom_range(0, 9) < 7);
            else
                drive($urandom_range(0, 9) < 7, $urandom_range(0, 63), $urandom_range(0, 63),
                      $urandom_range(0, 9) < 7);
            @(negedge Clk);
            vectors++;
            if (OutValid !== m_valid || MulBusy !== (m_left > 0) || InReady !== exp_ready()) begin
                miscompares++;
                $display("[TB] FAIL rand_hs_%0d: got valid=%0b busy=%0b ready=%0b want %0b/%0b/%0b",
                         n, OutValid, MulBusy, InReady, m_valid, (m_left > 0), exp_ready());
            end
            if (m_valid) begin
                vectors++;
                if (ALUControl !== m_ctrl || IllegalOp !== m_ill) begin
                    miscompares++;
                    $display("[TB] FAIL rand_data_%0d: got ctrl=%0d ill=%0b want %0d/%0b",
                             n, ALUControl, IllegalOp, m_ctrl, m_ill);
                end
            end
            step();
        end
        Reset = 0;
    endtask

    initial begin
        rmap[32] = 0; rmap[34] = 1; rmap[24] = 8; rmap[36] = 2; rmap[37] = 3;
        rmap[39] = 4; rmap[38] = 5; rmap[0]  = 6; rmap[2]  = 7; rmap[42] = 9;
        omap[8] = 0; omap[35] = 0; omap[43] = 0; omap[40] = 0; omap[33] = 0;
        omap[32] = 0; omap[41] = 0; omap[4] = 1; omap[9] = 10; omap[5] = 11;
        omap[7] = 12; omap[6] = 13; omap[11] = 14; omap[12] = 2; omap[13] = 3;
        omap[14] = 5; omap[10] = 9;
        step();
        test_reset();
        test_stream();
        test_backpressure();
        test_mul();
        test_mul_single();
        test_illegal();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_control_pipe.md
# alu_control_pipe

Registered, handshaked successor to the single-cycle ALU control decoder. It decodes the MIPS OpCode/Function pair into an ALU operation code and holds it in an output register with valid/ready flow control. It stalls the front end for a parametrised number of cycles on multiply, and flags illegal encodings. It sits between the ID stage register and the EX-stage ALU/multiplier.

## Interface
- CTRL_W, 4, ALUControl width; must be ≥ 4; codes zero-extended to CTRL_W.
- MUL_CYCLES, 3, total accept-to-output latency for multiply; legal range 1–16.
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  OpCode/Function valid this cycle.
- InReady  output  1  block can accept an instruction this cycle.
- OpCode  input  6  instruction bits [31:26].
- Function  input  6  instruction bits [5:0]; used only when OpCode == 0.
- OutValid  output  1  ALUControl/IllegalOp hold a decoded result.
- OutReady  input  1  EX stage consumes the result this cycle.
- ALUControl  output  CTRL_W  decoded ALU operation.
- IllegalOp  output  1  decoded instruction was not in the table.
- MulBusy  output  1  multiply latency counter running.

## Operation
- Decode table, R-type (OpCode 0) by Function:
  - 32→0, 34→1, 24→8 (mul), 36→2, 37→3, 39→4, 38→5, 0→6, 2→7, 42→9.
- Decode table, by OpCode:
  - 8, 35, 43, 40, 33, 32, 41→0; 4→1; 9→10; 5→11; 7→12; 6→13; 11→14; 12→2; 13→3; 14→5; 10→9.
- Any other encoding is illegal (see Configuration).
- Accept: an instruction is accepted on a cycle where InValid && InReady.
- InReady = (state != MUL) && (!OutValid || OutReady), i.e. the output register is empty or being drained in the same cycle.
- FSM states and transitions:
  - IDLE: no result held. Accept non-mul → FULL. Accept mul → MUL (or → FULL if MUL_CYCLES == 1).
  - FULL: result held, OutValid = 1. OutReady without a new accept → IDLE. OutReady with a new accept → FULL (non-mul) or MUL (mul).
  - MUL: counter loaded with MUL_CYCLES-2 and decrements each cycle. At 0, load ALUControl = 8 and go → FULL.
- Output register holds its value while OutValid && !OutReady. Inputs are ignored when not accepted.
- The counter is 4 bits wide and never wraps: decrement stops at 0.

## Timing
- Reset values: ALUControl = 0, OutValid = 0, IllegalOp = 0, MulBusy = 0, state IDLE, counter 0. InReady = 1 the cycle after Reset deasserts.
- Non-mul latency: result visible on OutValid 1 cycle after accept. Back-to-back accepts sustain 1 result/cycle when OutReady is held high.
- Mul latency: OutValid rises MUL_CYCLES cycles after accept. MulBusy = 1 on exactly MUL_CYCLES-1 cycles. InReady = 0 throughout MUL.
- Simultaneous drain and accept in FULL: the old result is consumed and the new one loads on the same edge with no bubble.
- Reset mid-MUL or while FULL: the pending result is discarded and all outputs return to reset values on the next edge.
- OutReady asserted while OutValid = 0 has no effect.

## Configuration
- Macro ALUCTL_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal encoding is accepted normally.
  - Result is ALUControl = all ones of CTRL_W (15 at default) with IllegalOp = 1 and 1-cycle latency.
  - IllegalOp is 0 for all legal results.
- Undefined:
  - IllegalOp is tied to 0.
  - An illegal encoding is accepted, and OutValid asserts with ALUControl retaining its previously registered value.

## Test plan
- Reset, then add: Reset 2 cycles, then OpCode 0, Function 32, InValid 1, OutReady 1 → next cycle OutValid 1, ALUControl 0, IllegalOp 0.
- Stream with backpressure: beq (4), bne (5), ori (13) streamed back-to-back → ALUControl 1, 11, 3 on consecutive cycles. With OutReady 0 for 3 cycles, the second result is held and InReady = 0 until drained.
- Multiply latency: mul (Function 24) with MUL_CYCLES = 3 → MulBusy high 2 cycles, InReady 0, then OutValid with ALUControl 8 exactly 3 cycles after accept. Repeat with MUL_CYCLES = 1 → 1-cycle latency, MulBusy never high.
- Illegal encoding: OpCode 63 with ALUCTL_ILLEGAL_TRAP_EN defined → ALUControl 15, IllegalOp 1. Without the macro, after a prior slt (9) → ALUControl 9, IllegalOp 0, OutValid 1.
- Reset mid-operation: Reset asserted during the second MUL cycle → next cycle OutValid 0, MulBusy 0, InReady 1, and no ALUControl 8 result ever emitted.
- Drain with simultaneous accept: FULL with xori (14) held, OutReady 1 and sll (OpCode 0, Function 0) accepted in the same cycle → next cycle ALUControl 6, OutValid 1, with no idle cycle between results.
